// File: rtl/gf180mcu_ocd_io__pad_pkg.sv
// Shared types for the bidirectional pad controller:
// mode/pull encodings, FSM states and the captured pad config.
package gf180mcu_ocd_io__pad_pkg;

   typedef enum logic [1:0] {
      MODE_HIZ = 2'b00,
      MODE_IN  = 2'b01,
      MODE_OUT = 2'b10,
      MODE_ANA = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      PULL_NONE = 2'b00,
      PULL_DOWN = 2'b01,
      PULL_UP   = 2'b10,
      PULL_RSVD = 2'b11
   } pull_e;

   typedef enum logic [2:0] {
      S_HIZ  = 3'd0,
      S_IN   = 3'd1,
      S_OUT  = 3'd2,
      S_ANA  = 3'd3,
      S_TURN = 3'd4
   } state_e;

   typedef struct packed {
      pull_e      pull;
      logic [1:0] drv;
      logic       slew;
      logic       schmitt;
   } cfg_t;

   // Last count of the input arm window (counts 0..ARM_LAST).
   localparam logic [1:0] ARM_LAST = 2'd2;

   function automatic state_e mode2state(mode_e m);
      unique case (m)
         MODE_IN:  return S_IN;
         MODE_OUT: return S_OUT;
         MODE_ANA: return S_ANA;
         default:  return S_HIZ;
      endcase
   endfunction

   // Returns {pu, pd}; the reserved code drives neither.
   function automatic logic [1:0] pull_bits(pull_e p);
      unique case (p)
         PULL_UP:   return 2'b10;
         PULL_DOWN: return 2'b01;
         default:   return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__bi_ctrl_if.sv
// Mode/config request channel between core GPIO logic
// and the pad controller (valid/ready).
interface gf180mcu_ocd_io__bi_ctrl_if;

   logic [1:0] MODE;
   logic       MODE_VLD;
   logic       MODE_RDY;
   logic [1:0] PULL;
   logic [1:0] DRV;
   logic       SLEW;
   logic       SCHMITT;

   modport master (
      output MODE,
      output MODE_VLD,
      output PULL,
      output DRV,
      output SLEW,
      output SCHMITT,
      input  MODE_RDY
   );

   modport slave (
      input  MODE,
      input  MODE_VLD,
      input  PULL,
      input  DRV,
      input  SLEW,
      input  SCHMITT,
      output MODE_RDY
   );

endinterface

// File: rtl/gf180mcu_ocd_io__in_filt.sv
// Pad receive path: 2-flop synchronizer, arm window after
// entering input mode, debounce counter and DIN edge pulses.
module gf180mcu_ocd_io__in_filt
   import gf180mcu_ocd_io__pad_pkg::*;
#(
   parameter int unsigned DEB_CYC = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic Y,
   output logic DIN,
   output logic DIN_RISE,
   output logic DIN_FALL
);

   localparam logic [7:0] DEB_LIM = 8'(DEB_CYC);

   logic       sync1;
   logic       sync2;
   logic [1:0] arm_cnt;
   logic       armed;
   logic [7:0] cnt;

   // Synchronizer; flushed to 0 whenever the input path is off.
   always_ff @(posedge CLK) begin
      if (RST || !en) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= Y;
         sync2 <= sync1;
      end
   end

   // Arm window, debounce and pulses; DEB_CYC=0 updates on the first mismatch.
   always_ff @(posedge CLK) begin
      if (RST) begin
         arm_cnt  <= '0;
         armed    <= 1'b0;
         cnt      <= '0;
         DIN      <= 1'b0;
         DIN_RISE <= 1'b0;
         DIN_FALL <= 1'b0;
      end else begin
         DIN_RISE <= 1'b0;
         DIN_FALL <= 1'b0;
         if (!en) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
            cnt     <= '0;
         end else if (!armed) begin
            if (arm_cnt == ARM_LAST) begin
               armed <= 1'b1;
               DIN   <= sync2;
            end else begin
               arm_cnt <= arm_cnt + 2'd1;
            end
         end else if (sync2 == DIN) begin
            cnt <= '0;
         end else if (cnt == DEB_LIM) begin
            DIN      <= sync2;
            cnt      <= '0;
            DIN_RISE <= sync2;
            DIN_FALL <= ~sync2;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/gf180mcu_ocd_io__bi_ctrl.sv
// Core-side controller for one bidirectional pad: mode FSM with
// break-before-make turnaround, config capture, registered pad pins.
module gf180mcu_ocd_io__bi_ctrl
   import gf180mcu_ocd_io__pad_pkg::*;
#(
   parameter int unsigned TURN_CYC = 2,
   parameter int unsigned DEB_CYC  = 4
) (
   input  logic       CLK,
   input  logic       RST,
   gf180mcu_ocd_io__bi_ctrl_if.slave req,
   input  logic       DOUT,
   output logic [1:0] CUR_MODE,
   output logic       DIN,
   output logic       DIN_RISE,
   output logic       DIN_FALL,
   output logic       OE,
   output logic       IE,
   output logic       A,
   output logic       PU,
   output logic       PD,
   output logic       SL,
   output logic       PDRV0,
   output logic       PDRV1,
   output logic       CS,
   input  logic       Y
);

   localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

   state_e     state;
   state_e     nxt_state;
   mode_e      tgt;
   mode_e      nxt_tgt;
   mode_e      cur_mode;
   mode_e      nxt_cur;
   mode_e      req_mode;
   logic [3:0] tcnt;
   logic [3:0] nxt_tcnt;
   cfg_t       cfg;
   cfg_t       nxt_cfg;
   logic       rdy;
   logic       accept;
   logic       in_en;
   logic       nxt_oe;
   logic       nxt_ie;
   logic       nxt_pu;
   logic       nxt_pd;

   assign rdy          = (state != S_TURN);
   assign req.MODE_RDY = rdy;
   assign accept       = req.MODE_VLD & rdy;
   assign req_mode     = mode_e'(req.MODE);
   assign CUR_MODE     = cur_mode;
   assign in_en        = (state == S_IN);

   // Next state: hold in turnaround, else accept and capture.
   always_comb begin
      nxt_state = state;
      nxt_tgt   = tgt;
      nxt_cur   = cur_mode;
      nxt_tcnt  = tcnt;
      nxt_cfg   = cfg;
      if (state == S_TURN) begin
         if (tcnt == TURN_LAST) begin
            nxt_state = mode2state(tgt);
            nxt_cur   = tgt;
            nxt_tcnt  = '0;
         end else begin
            nxt_tcnt = tcnt + 4'd1;
         end
      end else if (accept) begin
         nxt_cfg.pull    = pull_e'(req.PULL);
         nxt_cfg.drv     = req.DRV;
         nxt_cfg.slew    = req.SLEW;
         nxt_cfg.schmitt = req.SCHMITT;
         if (req_mode != cur_mode) begin
            nxt_state = S_TURN;
            nxt_tgt   = req_mode;
            nxt_tcnt  = '0;
         end
      end
   end

   // Pad enables for the state being entered, so pins track state.
   always_comb begin
      nxt_oe = 1'b0;
      nxt_ie = 1'b0;
      nxt_pu = 1'b0;
      nxt_pd = 1'b0;
      unique case (nxt_state)
         S_HIZ: begin
            {nxt_pu, nxt_pd} = pull_bits(nxt_cfg.pull);
         end
         S_IN: begin
            nxt_ie           = 1'b1;
            {nxt_pu, nxt_pd} = pull_bits(nxt_cfg.pull);
         end
         S_OUT: begin
            nxt_oe = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // FSM, turnaround counter and captured config.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_HIZ;
         tgt      <= MODE_HIZ;
         cur_mode <= MODE_HIZ;
         tcnt     <= '0;
         cfg      <= '0;
      end else begin
         state    <= nxt_state;
         tgt      <= nxt_tgt;
         cur_mode <= nxt_cur;
         tcnt     <= nxt_tcnt;
         cfg      <= nxt_cfg;
      end
   end

   // Registered pad control pins.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OE    <= 1'b0;
         IE    <= 1'b0;
         A     <= 1'b0;
         PU    <= 1'b0;
         PD    <= 1'b0;
         SL    <= 1'b0;
         PDRV0 <= 1'b0;
         PDRV1 <= 1'b0;
         CS    <= 1'b0;
      end else begin
         OE    <= nxt_oe;
         IE    <= nxt_ie;
         A     <= DOUT;
         PU    <= nxt_pu;
         PD    <= nxt_pd;
         SL    <= nxt_cfg.slew;
         PDRV0 <= nxt_cfg.drv[0];
         PDRV1 <= nxt_cfg.drv[1];
         CS    <= nxt_cfg.schmitt;
      end
   end

   gf180mcu_ocd_io__in_filt #(
      .DEB_CYC (DEB_CYC)
   ) u_filt (
      .CLK      (CLK),
      .RST      (RST),
      .en       (in_en),
      .Y        (Y),
      .DIN      (DIN),
      .DIN_RISE (DIN_RISE),
      .DIN_FALL (DIN_FALL)
   );

endmodule

// File: tb/tb_gf180mcu_ocd_io__bi_ctrl.sv
// Scoreboard bench for the pad controller: stimulus queues expected
// pin values per cycle, a negedge monitor pops and compares them.
module tb_gf180mcu_ocd_io__bi_ctrl;

   localparam int O_OE     = 0;
   localparam int O_IE     = 1;
   localparam int O_A      = 2;
   localparam int O_PU     = 3;
   localparam int O_PD     = 4;
   localparam int O_SL     = 5;
   localparam int O_DRV    = 6;
   localparam int O_CS     = 7;
   localparam int O_RDY    = 8;
   localparam int O_CUR    = 9;
   localparam int O_DIN    = 10;
   localparam int O_RISE   = 11;
   localparam int O_NRISE  = 12;
   localparam int O_NFALL  = 13;
   localparam int O_IE0    = 14;
   localparam int O_CUR0   = 15;
   localparam int O_DIN0   = 16;
   localparam int O_NRISE0 = 17;
   localparam int O_NFALL0 = 18;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   logic DOUT, Y, Y0;
   logic [1:0] CUR_MODE, cur0;
   logic DIN, DIN_RISE, DIN_FALL, din0, rise0, fall0;
   logic OE, IE, A, PU, PD, SL, PDRV0, PDRV1, CS;
   logic oe0, ie0, a0, pu0, pd0, sl0, pdrv00, pdrv10, cs0;

   int   edges = 0;
   int   tests = 0;
   int   fails = 0;
   int   n_rise = 0, n_fall = 0, n_rise0 = 0, n_fall0 = 0;
   bit   done = 1'b0;
   exp_t sb[$];
   int   k, k2, g, h, t;

   gf180mcu_ocd_io__bi_ctrl_if bus ();
   gf180mcu_ocd_io__bi_ctrl_if bus0 ();

   gf180mcu_ocd_io__bi_ctrl #(.TURN_CYC(2), .DEB_CYC(4)) dut (
      .CLK(CLK), .RST(RST), .req(bus), .DOUT(DOUT),
      .CUR_MODE(CUR_MODE), .DIN(DIN), .DIN_RISE(DIN_RISE),
      .DIN_FALL(DIN_FALL), .OE(OE), .IE(IE), .A(A), .PU(PU),
      .PD(PD), .SL(SL), .PDRV0(PDRV0), .PDRV1(PDRV1), .CS(CS),
      .Y(Y)
   );

   gf180mcu_ocd_io__bi_ctrl #(.TURN_CYC(1), .DEB_CYC(0)) dut0 (
      .CLK(CLK), .RST(RST), .req(bus0), .DOUT(DOUT),
      .CUR_MODE(cur0), .DIN(din0), .DIN_RISE(rise0),
      .DIN_FALL(fall0), .OE(oe0), .IE(ie0), .A(a0), .PU(pu0),
      .PD(pd0), .SL(sl0), .PDRV0(pdrv00), .PDRV1(pdrv10), .CS(cs0),
      .Y(Y0)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) edges <= edges + 1;

   function automatic logic [31:0] obs(int sel);
      case (sel)
         O_OE:     return {31'd0, OE};
         O_IE:     return {31'd0, IE};
         O_A:      return {31'd0, A};
         O_PU:     return {31'd0, PU};
         O_PD:     return {31'd0, PD};
         O_SL:     return {31'd0, SL};
         O_DRV:    return {30'd0, PDRV1, PDRV0};
         O_CS:     return {31'd0, CS};
         O_RDY:    return {31'd0, bus.MODE_RDY};
         O_CUR:    return {30'd0, CUR_MODE};
         O_DIN:    return {31'd0, DIN};
         O_RISE:   return {31'd0, DIN_RISE};
         O_NRISE:  return 32'(n_rise);
         O_NFALL:  return 32'(n_fall);
         O_IE0:    return {31'd0, ie0};
         O_CUR0:   return {30'd0, cur0};
         O_DIN0:   return {31'd0, din0};
         O_NRISE0: return 32'(n_rise0);
         O_NFALL0: return 32'(n_fall0);
         default:  return '1;
      endcase
   endfunction

   function automatic void exp_at(int c, int s, logic [31:0] v, string n);
      exp_t e;
      e.cyc  = c;
      e.sel  = s;
      e.val  = v;
      e.name = n;
      sb.push_back(e);
   endfunction

   // Monitor: pin exclusivity every cycle, then due scoreboard entries.
   always @(negedge CLK) begin
      logic [31:0] got;
      tests++;
      if ((PU & PD) === 1'b1 || (OE & IE) === 1'b1) begin
         fails++;
         $display("FAIL pad_excl cyc=%0d OE=%b IE=%b PU=%b PD=%b (want no pair both 1)",
                  edges, OE, IE, PU, PD);
      end
      if (DIN_RISE === 1'b1) n_rise++;
      if (DIN_FALL === 1'b1) n_fall++;
      if (rise0 === 1'b1) n_rise0++;
      if (fall0 === 1'b1) n_fall0++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (done || sb[i].cyc <= edges) begin
            tests++;
            got = obs(sb[i].sel);
            if (sb[i].cyc != edges || got !== sb[i].val) begin
               fails++;
               $display("FAIL %s cyc=%0d got=%0h want=%0h (due %0d)",
                        sb[i].name, edges, got, sb[i].val, sb[i].cyc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic drive(logic [1:0] m, logic [1:0] p, logic [1:0] d,
                        logic s, logic c);
      bus.MODE     = m;
      bus.PULL     = p;
      bus.DRV      = d;
      bus.SLEW     = s;
      bus.SCHMITT  = c;
      bus.MODE_VLD = 1'b1;
   endtask

   initial begin
      RST = 1'b1;
      DOUT = 1'b0;
      Y = 1'b0;
      Y0 = 1'b0;
      bus.MODE = 2'b00; bus.PULL = 2'b00; bus.DRV = 2'b00;
      bus.SLEW = 1'b0; bus.SCHMITT = 1'b0; bus.MODE_VLD = 1'b0;
      bus0.MODE = 2'b00; bus0.PULL = 2'b00; bus0.DRV = 2'b00;
      bus0.SLEW = 1'b0; bus0.SCHMITT = 1'b0; bus0.MODE_VLD = 1'b0;
      tick(3);

      // reset state
      RST = 1'b0;
      k = edges + 1;
      exp_at(k, O_OE, 0, "rst_oe");
      exp_at(k, O_IE, 0, "rst_ie");
      exp_at(k, O_PU, 0, "rst_pu");
      exp_at(k, O_PD, 0, "rst_pd");
      exp_at(k, O_A, 0, "rst_a");
      exp_at(k, O_SL, 0, "rst_sl");
      exp_at(k, O_DRV, 0, "rst_drv");
      exp_at(k, O_CS, 0, "rst_cs");
      exp_at(k, O_RDY, 1, "rst_rdy");
      exp_at(k, O_CUR, 0, "rst_cur");
      exp_at(k, O_DIN, 0, "rst_din");
      tick(2);

      // DOUT -> A one cycle
      DOUT = 1'b1;
      exp_at(edges + 1, O_A, 1, "a_hi");
      tick(1);
      DOUT = 1'b0;
      exp_at(edges + 1, O_A, 0, "a_lo");
      tick(1);

      // HIZ -> OUT with turnaround; second unit goes to IN
      drive(2'b10, 2'b10, 2'b11, 1'b1, 1'b0);
      bus0.MODE = 2'b01;
      bus0.MODE_VLD = 1'b1;
      k = edges + 1;
      exp_at(k, O_OE, 0, "t2_oe_brk");
      exp_at(k, O_IE, 0, "t2_ie_brk");
      exp_at(k, O_RDY, 0, "t2_rdy_brk");
      exp_at(k, O_PU, 0, "t2_pu_brk");
      exp_at(k, O_CUR, 0, "t2_cur_brk");
      exp_at(k, O_DRV, 3, "t2_drv_brk");
      exp_at(k, O_SL, 1, "t2_sl_brk");
      exp_at(k + 1, O_OE, 0, "t2_oe_turn");
      exp_at(k + 1, O_RDY, 0, "t2_rdy_turn");
      exp_at(k + 2, O_OE, 1, "t2_oe_on");
      exp_at(k + 2, O_IE, 0, "t2_ie_on");
      exp_at(k + 2, O_PU, 0, "t2_pu_on");
      exp_at(k + 2, O_PD, 0, "t2_pd_on");
      exp_at(k + 2, O_DRV, 3, "t2_drv_on");
      exp_at(k + 2, O_RDY, 1, "t2_rdy_on");
      exp_at(k + 2, O_CUR, 2, "t2_cur_on");
      exp_at(k, O_IE0, 0, "u0_ie_brk");
      exp_at(k + 1, O_IE0, 1, "u0_ie_on");
      exp_at(k + 1, O_CUR0, 1, "u0_cur_on");
      tick(1);
      bus.MODE_VLD = 1'b0;
      bus0.MODE_VLD = 1'b0;
      tick(3);

      // OUT -> IN, pull down
      drive(2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
      k = edges + 1;
      exp_at(k, O_OE, 0, "t3_oe_brk");
      exp_at(k, O_IE, 0, "t3_ie_brk");
      exp_at(k, O_PD, 0, "t3_pd_brk");
      exp_at(k, O_RDY, 0, "t3_rdy_brk");
      exp_at(k, O_CS, 1, "t3_cs_brk");
      exp_at(k, O_SL, 0, "t3_sl_brk");
      exp_at(k + 1, O_IE, 0, "t3_ie_turn");
      exp_at(k + 2, O_IE, 1, "t3_ie_on");
      exp_at(k + 2, O_OE, 0, "t3_oe_on");
      exp_at(k + 2, O_PD, 1, "t3_pd_on");
      exp_at(k + 2, O_PU, 0, "t3_pu_on");
      exp_at(k + 2, O_CUR, 1, "t3_cur_on");
      exp_at(k + 2, O_RDY, 1, "t3_rdy_on");
      tick(1);
      bus.MODE_VLD = 1'b0;
      tick(10);
      exp_at(edges + 1, O_DIN, 0, "t3_din_armed");

      // 3-cycle glitch is filtered
      g = edges;
      Y = 1'b1;
      exp_at(g + 4, O_DIN, 0, "glitch_din4");
      exp_at(g + 6, O_DIN, 0, "glitch_din6");
      exp_at(g + 8, O_DIN, 0, "glitch_din8");
      exp_at(g + 8, O_NRISE, 0, "glitch_nrise");
      tick(3);
      Y = 1'b0;
      tick(6);

      // held high: DIN rises after 7 cycles, one pulse
      h = edges;
      Y = 1'b1;
      exp_at(h + 6, O_DIN, 0, "hold_din6");
      exp_at(h + 7, O_DIN, 1, "hold_din7");
      exp_at(h + 7, O_RISE, 1, "hold_rise7");
      exp_at(h + 8, O_RISE, 0, "hold_rise8");
      exp_at(h + 10, O_NRISE, 1, "hold_nrise");
      exp_at(h + 10, O_NFALL, 0, "hold_nfall");
      tick(12);

      // same-mode config updates, no turnaround
      drive(2'b01, 2'b10, 2'b00, 1'b0, 1'b1);
      k = edges + 1;
      exp_at(k, O_PU, 1, "t5_pu_up");
      exp_at(k, O_PD, 0, "t5_pd_up");
      exp_at(k, O_IE, 1, "t5_ie_up");
      exp_at(k, O_RDY, 1, "t5_rdy_up");
      exp_at(k, O_CUR, 1, "t5_cur_up");
      tick(1);
      bus.PULL = 2'b01;
      k2 = edges + 1;
      exp_at(k2, O_PU, 0, "t5_pu_dn");
      exp_at(k2, O_PD, 1, "t5_pd_dn");
      exp_at(k2, O_IE, 1, "t5_ie_dn");
      exp_at(k2, O_RDY, 1, "t5_rdy_dn");
      exp_at(k2, O_DIN, 1, "t5_din");
      exp_at(k2 + 1, O_IE, 1, "t5_ie_after");
      tick(1);
      bus.MODE_VLD = 1'b0;
      tick(2);

      // bypass unit: Y0 toggles every 4 cycles
      t = edges;
      Y0 = 1'b1;
      exp_at(t + 2, O_DIN0, 0, "byp_din2");
      exp_at(t + 3, O_DIN0, 1, "byp_din3");
      exp_at(t + 4, O_NRISE0, 1, "byp_nrise4");
      exp_at(t + 6, O_DIN0, 1, "byp_din6");
      exp_at(t + 7, O_DIN0, 0, "byp_din7");
      exp_at(t + 10, O_DIN0, 0, "byp_din10");
      exp_at(t + 11, O_DIN0, 1, "byp_din11");
      exp_at(t + 14, O_DIN0, 1, "byp_din14");
      exp_at(t + 15, O_DIN0, 0, "byp_din15");
      exp_at(t + 16, O_NRISE0, 2, "byp_nrise");
      exp_at(t + 16, O_NFALL0, 2, "byp_nfall");
      tick(4);
      Y0 = 1'b0;
      tick(4);
      Y0 = 1'b1;
      tick(4);
      Y0 = 1'b0;
      tick(5);

      // reset in the first turnaround cycle
      drive(2'b00, 2'b01, 2'b01, 1'b1, 1'b1);
      k = edges + 1;
      exp_at(k, O_RDY, 0, "t7_rdy_turn");
      exp_at(k, O_IE, 0, "t7_ie_turn");
      exp_at(k, O_PD, 0, "t7_pd_turn");
      exp_at(k, O_SL, 1, "t7_sl_turn");
      exp_at(k, O_DRV, 1, "t7_drv_turn");
      tick(1);
      RST = 1'b1;
      bus.MODE_VLD = 1'b0;
      exp_at(k + 1, O_OE, 0, "t7_oe");
      exp_at(k + 1, O_IE, 0, "t7_ie");
      exp_at(k + 1, O_PU, 0, "t7_pu");
      exp_at(k + 1, O_PD, 0, "t7_pd");
      exp_at(k + 1, O_SL, 0, "t7_sl");
      exp_at(k + 1, O_DRV, 0, "t7_drv");
      exp_at(k + 1, O_CS, 0, "t7_cs");
      exp_at(k + 1, O_CUR, 0, "t7_cur");
      exp_at(k + 1, O_RDY, 1, "t7_rdy");
      exp_at(k + 1, O_DIN, 0, "t7_din");
      exp_at(k + 3, O_NFALL, 0, "t7_nfall");
      exp_at(k + 3, O_NRISE, 1, "t7_nrise");
      tick(1);
      RST = 1'b0;
      tick(4);

      done = 1'b1;
      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
